// File: rtl/axi_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite register self-test master.
package axi_selftest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RADDR,
        RDATA,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam int          DATA_W    = 32;
    localparam int          STRB_W    = 4;

endpackage

// File: rtl/lfsr32_step.sv
// One step of the 32-bit Galois LFSR: shift right, fold in the mask when the old LSB was set.
module lfsr32_step
    import axi_selftest_pkg::*;
(
    input  logic [DATA_W-1:0] cur_i,
    output logic [DATA_W-1:0] nxt_o
);

    assign nxt_o = (cur_i >> 1) ^ (cur_i[0] ? LFSR_MASK : '0);

endmodule

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite master running a write/readback register self-test against a slave.
// Optional watchdog per waiting state is enabled by defining AXI_SELFTEST_TIMEOUT_EN.
module axi_lite_selftest_master
    import axi_selftest_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_VECTORS        = 4,
    parameter logic [31:0] BASE_ADDR          = 32'h0,
    parameter int unsigned ADDR_STRIDE        = 4,
    parameter logic [31:0] SEED               = 32'h0101FFFF,
    parameter int unsigned MODE               = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [15:0]                   err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_W-1:0]             M_AXI_WDATA,
    output logic [STRB_W-1:0]             M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_W-1:0]             M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    // state | meaning
    // IDLE  | waiting for start
    // WR    | AW and W offered, each held until its own handshake
    // WRESP | waiting for BVALID
    // RADDR | AR offered
    // RDATA | waiting for RVALID, capture data/resp
    // CHECK | compare captured readback with expected data
    // DONE  | one-cycle done pulse, pass valid

    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned CNT_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [AW-1:0]    BASE_A    = AW'(BASE_ADDR);
    localparam logic [AW-1:0]    STRIDE_A  = AW'(ADDR_STRIDE);
    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(NUM_VECTORS - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  wr_lfsr_q, wr_lfsr_d, rd_lfsr_q, rd_lfsr_d;
    logic [DATA_W-1:0]  wr_lfsr_nxt, rd_lfsr_nxt;
    logic [CNT_W-1:0]   wr_left_q, wr_left_d, rd_left_q, rd_left_d;
    logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [AW-1:0]      first_err_q, first_err_d;
    logic               pass_q, pass_d;
    logic               err_hit;
    logic [AW-1:0]      err_addr;
    logic               aw_hs, w_hs;

    lfsr32_step u_wr_lfsr (.cur_i(wr_lfsr_q), .nxt_o(wr_lfsr_nxt));
    lfsr32_step u_rd_lfsr (.cur_i(rd_lfsr_q), .nxt_o(rd_lfsr_nxt));

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

`ifdef AXI_SELFTEST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            in_wait;
    assign in_wait = (state_q == WR) || (state_q == WRESP) ||
                     (state_q == RADDR) || (state_q == RDATA);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_lfsr_d   = wr_lfsr_q;
        rd_lfsr_d   = rd_lfsr_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        err_hit     = 1'b0;
        err_addr    = wr_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WR;
                    wr_addr_d   = BASE_A;
                    rd_addr_d   = BASE_A;
                    wr_lfsr_d   = SEED;
                    rd_lfsr_d   = SEED;
                    wr_left_d   = LAST_LOAD;
                    rd_left_d   = LAST_LOAD;
                    err_count_d = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end
            WR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        err_hit  = 1'b1;
                        err_addr = wr_addr_q;
                    end
                    wr_addr_d = wr_addr_q + STRIDE_A;
                    wr_lfsr_d = wr_lfsr_nxt;
                    wr_left_d = wr_left_q - CNT_W'(1);
                    if ((MODE == 0) || (wr_left_q == '0)) begin
                        state_d = RADDR;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    rresp_d = M_AXI_RRESP;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((rresp_q != RESP_OKAY) || (rdata_q != rd_lfsr_q)) begin
                    err_hit  = 1'b1;
                    err_addr = rd_addr_q;
                end
                rd_addr_d = rd_addr_q + STRIDE_A;
                rd_lfsr_d = rd_lfsr_nxt;
                rd_left_d = rd_left_q - CNT_W'(1);
                if (rd_left_q == '0) begin
                    state_d = DONE;
                end else if (MODE == 0) begin
                    state_d = WR;
                end else begin
                    state_d = RADDR;
                end
            end
            DONE: begin
                pass_d  = (err_count_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_SELFTEST_TIMEOUT_EN
        // A handshake completing on the last allowed cycle wins over the timeout.
        wd_d = wd_q;
        if (in_wait && (wd_q == '0) && (state_d == state_q)) begin
            err_hit   = 1'b1;
            err_addr  = ((state_q == WR) || (state_q == WRESP)) ? wr_addr_q : rd_addr_q;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = DONE;
        end
        if (state_d != state_q) begin
            wd_d = WD_LOAD;
        end else if (wd_q != '0) begin
            wd_d = wd_q - WD_W'(1);
        end
`endif

        if (err_hit) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (err_count_q == '0) begin
                first_err_d = err_addr;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_lfsr_q   <= '0;
            rd_lfsr_q   <= '0;
            wr_left_q   <= '0;
            rd_left_q   <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_lfsr_q   <= wr_lfsr_d;
            rd_lfsr_q   <= rd_lfsr_d;
            wr_left_q   <= wr_left_d;
            rd_left_q   <= rd_left_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

`ifdef AXI_SELFTEST_TIMEOUT_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign M_AXI_AWADDR  = wr_addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
    assign M_AXI_WDATA   = wr_lfsr_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = (state_q == WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WRESP);
    assign M_AXI_ARADDR  = rd_addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == RADDR);
    assign M_AXI_RREADY  = (state_q == RDATA);

    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign pass           = done ? (err_count_q == '0) : pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Bench: two masters (interleaved defaults, batch at 0x40) against configurable RAM slaves.
module tb_axi_lite_selftest_master;

    localparam logic [31:0] SEED_C = 32'h0101FFFF;
    localparam logic [31:0] MASK_C = 32'h80200003;
    localparam int NV     [2] = '{4, 8};
    localparam int BASE   [2] = '{0, 'h40};
    localparam int MODE_A [2] = '{0, 1};

    logic clk = 1'b0;
    logic areset;
    logic        start_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        pass_s  [2];
    logic [15:0] errc    [2];
    logic [31:0] fea     [2];
    logic [31:0] awaddr  [2];
    logic [2:0]  awprot  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic [2:0]  arprot  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    int aw_dly [2];
    int w_dly  [2];
    logic flip_en [2];
    logic slverr_en [2];
    logic ar_stuck [2];

    logic [31:0] exp_aw [2][$];
    logic [31:0] exp_w  [2][$];
    logic [31:0] exp_ar [2][$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? MASK_C : 32'h0);
    endfunction

    axi_lite_selftest_master #(.TIMEOUT_CYCLES(16)) u0 (
        .ACLK(clk), .ARESET(areset), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(errc[0]), .first_err_addr(fea[0]),
        .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWPROT(awprot[0]), .M_AXI_AWVALID(awvalid[0]),
        .M_AXI_AWREADY(awready[0]), .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]),
        .M_AXI_WVALID(wvalid[0]), .M_AXI_WREADY(wready[0]), .M_AXI_BRESP(bresp[0]),
        .M_AXI_BVALID(bvalid[0]), .M_AXI_BREADY(bready[0]), .M_AXI_ARADDR(araddr[0]),
        .M_AXI_ARPROT(arprot[0]), .M_AXI_ARVALID(arvalid[0]), .M_AXI_ARREADY(arready[0]),
        .M_AXI_RDATA(rdata[0]), .M_AXI_RRESP(rresp[0]), .M_AXI_RVALID(rvalid[0]),
        .M_AXI_RREADY(rready[0])
    );

    axi_lite_selftest_master #(.NUM_VECTORS(8), .BASE_ADDR(32'h40), .MODE(1)) u1 (
        .ACLK(clk), .ARESET(areset), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(errc[1]), .first_err_addr(fea[1]),
        .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWPROT(awprot[1]), .M_AXI_AWVALID(awvalid[1]),
        .M_AXI_AWREADY(awready[1]), .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]),
        .M_AXI_WVALID(wvalid[1]), .M_AXI_WREADY(wready[1]), .M_AXI_BRESP(bresp[1]),
        .M_AXI_BVALID(bvalid[1]), .M_AXI_BREADY(bready[1]), .M_AXI_ARADDR(araddr[1]),
        .M_AXI_ARPROT(arprot[1]), .M_AXI_ARVALID(arvalid[1]), .M_AXI_ARREADY(arready[1]),
        .M_AXI_RDATA(rdata[1]), .M_AXI_RRESP(rresp[1]), .M_AXI_RVALID(rvalid[1]),
        .M_AXI_RREADY(rready[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_slv
        int          aw_wait = 0;
        int          w_wait  = 0;
        int          ar_cnt  = 0;
        logic        aw_got = 1'b0, w_got = 1'b0, aw_prev = 1'b0, w_prev = 1'b0;
        logic        bv = 1'b0, rv = 1'b0;
        logic [1:0]  br = 2'b00;
        logic [31:0] aw_a = '0, w_d = '0, rd = '0;
        logic [31:0] mem [64];
        logic        aw_hs, w_hs, ar_hs;
        logic [31:0] a_eff, d_eff;

        assign awready[g] = awvalid[g] && (aw_wait >= aw_dly[g]);
        assign wready[g]  = wvalid[g] && (w_wait >= w_dly[g]);
        assign arready[g] = arvalid[g] && !ar_stuck[g];
        assign bvalid[g]  = bv;
        assign bresp[g]   = br;
        assign rvalid[g]  = rv;
        assign rdata[g]   = rd;
        assign rresp[g]   = 2'b00;
        assign aw_hs = awvalid[g] && awready[g];
        assign w_hs  = wvalid[g] && wready[g];
        assign ar_hs = arvalid[g] && arready[g];
        assign a_eff = aw_got ? aw_a : awaddr[g];
        assign d_eff = w_got ? w_d : wdata[g];

        always @(posedge clk) begin
            if (areset) begin
                aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
                bv <= 1'b0; rv <= 1'b0;
            end else begin
                aw_wait <= (awvalid[g] && !awready[g]) ? aw_wait + 1 : 0;
                w_wait  <= (wvalid[g] && !wready[g]) ? w_wait + 1 : 0;
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr[g]; end
                if (w_hs)  begin w_got <= 1'b1;  w_d <= wdata[g];  end
                if (bv && bready[g]) bv <= 1'b0;
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    mem[a_eff[7:2]] <= d_eff;
                    br <= (slverr_en[g] && a_eff == 32'h4) ? 2'b10 : 2'b00;
                    bv <= 1'b1;
                    aw_got <= 1'b0;
                    w_got <= 1'b0;
                end
                if (rv && rready[g]) rv <= 1'b0;
                if (ar_hs) begin
                    rv <= 1'b1;
                    rd <= mem[araddr[g][7:2]] ^ {31'b0, flip_en[g] && araddr[g] == 32'h8};
                end
            end
        end

        // Scoreboard side: pop expected address/data on every observed handshake.
        always @(negedge clk) begin
            if (areset) begin
                aw_prev <= 1'b0;
                w_prev  <= 1'b0;
            end else begin
                if (aw_prev) chk("awvalid_drop", awvalid[g], 1'b0);
                if (w_prev)  chk("wvalid_drop", wvalid[g], 1'b0);
                aw_prev <= aw_hs;
                w_prev  <= w_hs;
                if (aw_hs) begin
                    if (exp_aw[g].size() == 0) chk("aw_unexpected", awvalid[g], 1'b0);
                    else chk("awaddr", awaddr[g], exp_aw[g].pop_front());
                end
                if (w_hs) begin
                    if (exp_w[g].size() == 0) chk("w_unexpected", wvalid[g], 1'b0);
                    else chk("wdata", wdata[g], exp_w[g].pop_front());
                end
                if (ar_hs) begin
                    ar_cnt <= ar_cnt + 1;
                    if (exp_ar[g].size() == 0) chk("ar_unexpected", arvalid[g], 1'b0);
                    else begin
                        chk("writes_before_ar", exp_aw[g].size(),
                            (MODE_A[g] == 1) ? 0 : exp_ar[g].size() - 1);
                        chk("araddr", araddr[g], exp_ar[g].pop_front());
                    end
                end
            end
        end
    end

    task automatic push_vectors(input int g);
        logic [31:0] d;
        logic [31:0] a;
        d = SEED_C;
        a = BASE[g];
        exp_aw[g].delete();
        exp_w[g].delete();
        exp_ar[g].delete();
        for (int i = 0; i < NV[g]; i++) begin
            exp_aw[g].push_back(a);
            exp_w[g].push_back(d);
            exp_ar[g].push_back(a);
            a = a + 32'd4;
            d = lfsr_next(d);
        end
    endtask

    task automatic run(input int g, input int budget, output int bc);
        bc = 0;
        @(negedge clk); start_s[g] = 1'b1;
        @(negedge clk); start_s[g] = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_s[g]) break;
            if (busy_s[g]) bc++;
            @(negedge clk);
        end
        chk("done_seen", done_s[g], 1'b1);
    endtask

    task automatic check_drained(input int g);
        chk("aw_left", exp_aw[g].size(), 0);
        chk("w_left", exp_w[g].size(), 0);
        chk("ar_left", exp_ar[g].size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int bc;
        int base_cnt;
        logic seen;
        areset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0; aw_dly[g] = 0; w_dly[g] = 0;
            flip_en[g] = 1'b0; slverr_en[g] = 1'b0; ar_stuck[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", busy_s[0], 1'b0);
        chk("rst_done", done_s[0], 1'b0);
        chk("rst_pass", pass_s[0], 1'b0);
        chk("rst_errc", errc[0], 16'h0);
        chk("rst_fea", fea[0], 32'h0);
        chk("rst_valids", {awvalid[0], wvalid[0], bready[0], arvalid[0], rready[0]}, 5'b0);
        chk("rst_addr_data", {awaddr[0], wdata[0], araddr[0]}, 96'h0);
        chk("fixed_prot_strb", {awprot[0], arprot[0], wstrb[0]}, {3'b000, 3'b000, 4'hF});

        // Interleaved, zero-wait slave
        push_vectors(0);
        run(0, 200, bc);
        chk("t1_pass", pass_s[0], 1'b1);
        chk("t1_errc", errc[0], 16'h0);
        chk("t1_fea", fea[0], 32'h0);
        chk("t1_busy_cycles", bc, 20);
        check_drained(0);
        @(negedge clk);
        chk("t1_pass_held", pass_s[0], 1'b1);
        chk("t1_done_pulse", done_s[0], 1'b0);

        // Batch mode, 8 vectors at 0x40
        push_vectors(1);
        run(1, 400, bc);
        chk("t2_pass", pass_s[1], 1'b1);
        chk("t2_errc", errc[1], 16'h0);
        check_drained(1);

        // Bit flip at 0x8 and SLVERR at 0x4
        flip_en[0] = 1'b1; slverr_en[0] = 1'b1;
        push_vectors(0);
        run(0, 200, bc);
        chk("t3_pass", pass_s[0], 1'b0);
        chk("t3_errc", errc[0], 16'd2);
        chk("t3_fea", fea[0], 32'h4);
        check_drained(0);
        flip_en[0] = 1'b0; slverr_en[0] = 1'b0;

        // Handshake ordering: AW late, W late, both together
        aw_dly[0] = 5; w_dly[0] = 0;
        push_vectors(0);
        run(0, 400, bc);
        chk("t4a_pass", pass_s[0], 1'b1);
        check_drained(0);
        aw_dly[0] = 0; w_dly[0] = 5;
        push_vectors(0);
        run(0, 400, bc);
        chk("t4b_pass", pass_s[0], 1'b1);
        check_drained(0);
        aw_dly[0] = 3; w_dly[0] = 3;
        push_vectors(0);
        run(0, 400, bc);
        chk("t4c_pass", pass_s[0], 1'b1);
        check_drained(0);
        aw_dly[0] = 0; w_dly[0] = 0;

        // Reset during RDATA of vector 2
        push_vectors(0);
        base_cnt = g_slv[0].ar_cnt;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (g_slv[0].ar_cnt == base_cnt + 3 && rready[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_reached_rdata2", seen, 1'b1);
        areset = 1'b1;
        @(negedge clk);
        chk("t5_rst_valids", {awvalid[0], wvalid[0], bready[0], arvalid[0], rready[0]}, 5'b0);
        chk("t5_rst_status", {busy_s[0], done_s[0], pass_s[0]}, 3'b0);
        chk("t5_rst_errs", {errc[0], fea[0]}, 48'h0);
        chk("t5_rst_addr_data", {awaddr[0], wdata[0], araddr[0]}, 96'h0);
        areset = 1'b0;
        push_vectors(0);
        run(0, 200, bc);
        chk("t5_pass", pass_s[0], 1'b1);
        chk("t5_busy_cycles", bc, 20);
        check_drained(0);

`ifdef AXI_SELFTEST_TIMEOUT_EN
        begin : t6_timeout
            int cyc;
            int t_ar;
            int t_done;
            ar_stuck[0] = 1'b1;
            push_vectors(0);
            @(negedge clk); start_s[0] = 1'b1;
            @(negedge clk); start_s[0] = 1'b0;
            t_ar = -1; t_done = -1;
            for (cyc = 0; cyc < 200; cyc++) begin
                if (arvalid[0] && t_ar < 0) t_ar = cyc;
                if (done_s[0]) begin
                    t_done = cyc;
                    break;
                end
                @(negedge clk);
            end
            chk("t6_done_seen", done_s[0], 1'b1);
            chk("t6_latency", t_done - t_ar, 16);
            chk("t6_errc", errc[0], 16'd1);
            chk("t6_fea", fea[0], 32'h0);
            chk("t6_pass", pass_s[0], 1'b0);
            @(negedge clk);
            chk("t6_arvalid_low", arvalid[0], 1'b0);
            ar_stuck[0] = 1'b0;
            exp_aw[0].delete(); exp_w[0].delete(); exp_ar[0].delete();
        end
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
